// File: rtl/regfile_exec_seq.sv
// Execute/sequencer stage feeding a 2R/1W register RAM: read, execute, write back, done pulse.
// Optional multiplier for op 10 is enabled by defining EXEC_MUL_EN.
module regfile_exec_seq #(
   parameter int DW = 32,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [3:0]    instr_op,
   input  logic [AW-1:0] instr_rs1,
   input  logic [AW-1:0] instr_rs2,
   input  logic [AW-1:0] instr_rd,
   output logic [AW-1:0] addr_a,
   output logic [AW-1:0] addr_b,
   input  logic [DW-1:0] data_a,
   input  logic [DW-1:0] data_b,
   output logic [AW-1:0] addr_wr,
   output logic [DW-1:0] data_in,
   output logic          we,
   output logic          done,
   output logic [DW-1:0] result,
   output logic          illegal
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   logic [1:0]    state_q, state_d;
   logic          instr_ready_q, instr_ready_d;
   logic [3:0]    op_q, op_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] addr_a_q, addr_a_d;
   logic [AW-1:0] addr_b_q, addr_b_d;
   logic [AW-1:0] addr_wr_q, addr_wr_d;
   logic [DW-1:0] data_in_q, data_in_d;
   logic          we_q, we_d;
   logic          done_q, done_d;
   logic [DW-1:0] result_q, result_d;
   logic          illegal_q, illegal_d;

   logic [DW-1:0] alu_res;
   logic          op_legal;
   logic [4:0]    shamt;

   // op_q stays latched through WB, so legality is re-derived there instead of being stored
   always_comb begin
      alu_res  = '0;
      op_legal = 1'b1;
      shamt    = data_b[4:0];
      case (op_q)
         OP_ADD:  alu_res = data_a + data_b;
         OP_SUB:  alu_res = data_a - data_b;
         OP_AND:  alu_res = data_a & data_b;
         OP_OR:   alu_res = data_a | data_b;
         OP_XOR:  alu_res = data_a ^ data_b;
         OP_SLL:  alu_res = data_a << shamt;
         OP_SRL:  alu_res = data_a >> shamt;
         OP_SRA:  alu_res = $signed(data_a) >>> shamt;
         OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
         OP_SLTU: alu_res = {{(DW-1){1'b0}}, (data_a < data_b)};
`ifdef EXEC_MUL_EN
         OP_MUL:  alu_res = data_a * data_b;
`else
         OP_MUL:  op_legal = 1'b0;
`endif
         default: op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      instr_ready_d = instr_ready_q;
      op_d          = op_q;
      rd_d          = rd_q;
      addr_a_d      = addr_a_q;
      addr_b_d      = addr_b_q;
      addr_wr_d     = addr_wr_q;
      data_in_d     = data_in_q;
      we_d          = 1'b0;
      done_d        = 1'b0;
      result_d      = result_q;
      illegal_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            // ready comes up one edge after reset release, then gates acceptance
            instr_ready_d = 1'b1;
            if (instr_valid && instr_ready_q) begin
               op_d          = instr_op;
               rd_d          = instr_rd;
               addr_a_d      = instr_rs1;
               addr_b_d      = instr_rs2;
               instr_ready_d = 1'b0;
               state_d       = S_READ;
            end
         end
         S_READ: state_d = S_EXEC;
         S_EXEC: begin
            data_in_d = op_legal ? alu_res : '0;
            addr_wr_d = rd_q;
            we_d      = op_legal && (rd_q != '0);
            state_d   = S_WB;
         end
         default: begin
            done_d        = 1'b1;
            result_d      = data_in_q;
            illegal_d     = !op_legal;
            instr_ready_d = 1'b1;
            state_d       = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         instr_ready_q <= 1'b0;
         op_q          <= '0;
         rd_q          <= '0;
         addr_a_q      <= '0;
         addr_b_q      <= '0;
         addr_wr_q     <= '0;
         data_in_q     <= '0;
         we_q          <= 1'b0;
         done_q        <= 1'b0;
         result_q      <= '0;
         illegal_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_ready_q <= instr_ready_d;
         op_q          <= op_d;
         rd_q          <= rd_d;
         addr_a_q      <= addr_a_d;
         addr_b_q      <= addr_b_d;
         addr_wr_q     <= addr_wr_d;
         data_in_q     <= data_in_d;
         we_q          <= we_d;
         done_q        <= done_d;
         result_q      <= result_d;
         illegal_q     <= illegal_d;
      end
   end

   assign instr_ready = instr_ready_q;
   assign addr_a      = addr_a_q;
   assign addr_b      = addr_b_q;
   assign addr_wr     = addr_wr_q;
   assign data_in     = data_in_q;
   assign we          = we_q;
   assign done        = done_q;
   assign result      = result_q;
   assign illegal     = illegal_q;

endmodule
